// File: rtl/multi_timer_core.sv
// Multi-channel timer/counter core with a shared prescaler.
// Sticky write-1-to-clear event flags are combined into one IRQ.
module multi_timer_core #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8,
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SELW-1:0]           sel,
  input  logic                      countWe,
  input  logic [WIDTH-1:0]          countIn,
  input  logic                      reloadWe,
  input  logic [WIDTH-1:0]          reloadIn,
  input  logic                      configWe,
  input  logic [3:0]                configIn,
  input  logic                      prescaleWe,
  input  logic [PRESCALE_W-1:0]     prescaleIn,
  input  logic                      statusClrWe,
  input  logic [CHANNELS-1:0]       statusClrIn,
  output logic [CHANNELS*WIDTH-1:0] countOut,
  output logic [CHANNELS*WIDTH-1:0] reloadOut,
  output logic [CHANNELS*4-1:0]     configOut,
  output logic [PRESCALE_W-1:0]     prescaleOut,
  output logic [CHANNELS-1:0]       statusOut,
  output logic                      irq
);

  logic [WIDTH-1:0]      cnt [CHANNELS];
  logic [WIDTH-1:0]      rld [CHANNELS];
  logic [3:0]            cfg [CHANNELS];
  logic [CHANNELS-1:0]   status;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] psCnt;

  logic                tick;
  logic [CHANNELS-1:0] selHot;
  logic [CHANNELS-1:0] step;
  logic [CHANNELS-1:0] atEnd;
  logic [CHANNELS-1:0] evt;
  logic [CHANNELS-1:0] ire;

  // A prescale write restarts the period, so it suppresses the tick.
  assign tick = !prescaleWe && (psCnt == prescale);

  always_comb begin
    selHot = '0;
    step   = '0;
    atEnd  = '0;
    evt    = '0;
    ire    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      selHot[i] = (32'(sel) == i);
      step[i]   = tick && cfg[i][0];
      atEnd[i]  = cfg[i][1] ? (cnt[i] == rld[i])
                            : (cnt[i] == '0);
      evt[i]    = step[i] && atEnd[i]
                  && !(countWe && selHot[i]);
      ire[i]    = cfg[i][3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      psCnt    <= '0;
      status   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        rld[i] <= '0;
        cfg[i] <= '0;
      end
    end else begin
      if (prescaleWe) begin
        prescale <= prescaleIn;
        psCnt    <= '0;
      end else if (tick) begin
        psCnt <= '0;
      end else begin
        psCnt <= psCnt + PRESCALE_W'(1);
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (countWe && selHot[i]) begin
          cnt[i] <= countIn;
        end else if (step[i]) begin
          if (cfg[i][1])
            cnt[i] <= atEnd[i] ? '0 : cnt[i] + WIDTH'(1);
          else
            cnt[i] <= atEnd[i] ? rld[i] : cnt[i] - WIDTH'(1);
        end
        if (reloadWe && selHot[i])
          rld[i] <= reloadIn;
        if (configWe && selHot[i])
          cfg[i] <= configIn;
        else if (evt[i] && cfg[i][2])
          cfg[i][0] <= 1'b0;
        if (evt[i])
          status[i] <= 1'b1;
        else if (statusClrWe && statusClrIn[i])
          status[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    countOut  = '0;
    reloadOut = '0;
    configOut = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      countOut[i*WIDTH +: WIDTH]  = cnt[i];
      reloadOut[i*WIDTH +: WIDTH] = rld[i];
      configOut[i*4 +: 4]         = cfg[i];
    end
  end

  assign prescaleOut = prescale;
  assign statusOut   = status;
  assign irq         = |(status & ire);

endmodule

// File: tb/tb_multi_timer_core.sv
// Directed bench for multi_timer_core.
// A 3-channel instance covers out-of-range sel writes.
module tb_multi_timer_core;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   sel;
  logic         countWe;
  logic [31:0]  countIn;
  logic         reloadWe;
  logic [31:0]  reloadIn;
  logic         configWe;
  logic [3:0]   configIn;
  logic         prescaleWe;
  logic [7:0]   prescaleIn;
  logic         statusClrWe;
  logic [3:0]   statusClrIn;
  logic [127:0] countOut;
  logic [127:0] reloadOut;
  logic [15:0]  configOut;
  logic [7:0]   prescaleOut;
  logic [3:0]   statusOut;
  logic         irq;

  logic [23:0]  countOut3;
  logic [23:0]  reloadOut3;
  logic [11:0]  configOut3;
  logic [7:0]   prescaleOut3;
  logic [2:0]   statusOut3;
  logic         irq3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_timer_core dut (
    .clk(clk), .reset(reset), .sel(sel),
    .countWe(countWe), .countIn(countIn),
    .reloadWe(reloadWe), .reloadIn(reloadIn),
    .configWe(configWe), .configIn(configIn),
    .prescaleWe(prescaleWe), .prescaleIn(prescaleIn),
    .statusClrWe(statusClrWe), .statusClrIn(statusClrIn),
    .countOut(countOut), .reloadOut(reloadOut),
    .configOut(configOut), .prescaleOut(prescaleOut),
    .statusOut(statusOut), .irq(irq)
  );

  multi_timer_core #(.CHANNELS(3), .WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .sel(sel),
    .countWe(countWe), .countIn(countIn[7:0]),
    .reloadWe(reloadWe), .reloadIn(reloadIn[7:0]),
    .configWe(configWe), .configIn(configIn),
    .prescaleWe(prescaleWe), .prescaleIn(prescaleIn),
    .statusClrWe(statusClrWe), .statusClrIn(statusClrIn[2:0]),
    .countOut(countOut3), .reloadOut(reloadOut3),
    .configOut(configOut3), .prescaleOut(prescaleOut3),
    .statusOut(statusOut3), .irq(irq3)
  );

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    countWe     = 1'b0;
    reloadWe    = 1'b0;
    configWe    = 1'b0;
    prescaleWe  = 1'b0;
    statusClrWe = 1'b0;
    statusClrIn = '0;
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    sel = '0;
    countIn = '0;
    reloadIn = '0;
    configIn = '0;
    prescaleIn = '0;
    idle();
    step(2);
    chk("rstCount", countOut, 128'h0);
    chk("rstStatus", {statusOut, irq}, 5'h0);
    chk("rstPrescale", prescaleOut, 8'h0);
    reset = 1'b0;

    // ch0 up, reload 3, prescale 0
    sel = 2'd0;
    reloadWe = 1'b1; reloadIn = 32'd3;
    configWe = 1'b1; configIn = 4'b1011;
    step();
    idle();
    chk("upCfgEdge", countOut[31:0], 32'd0);
    step(); chk("up1", countOut[31:0], 32'd1);
    step(); chk("up2", countOut[31:0], 32'd2);
    step(); chk("up3", countOut[31:0], 32'd3);
    chk("upNoEvt", {statusOut, irq}, 5'h0);
    step(); chk("upWrap", countOut[31:0], 32'd0);
    chk("upEvt", {statusOut, irq}, {4'b0001, 1'b1});

    // stop ch0, zero it, clear flag
    configWe = 1'b1; configIn = 4'b0000;
    countWe = 1'b1; countIn = 32'd0;
    statusClrWe = 1'b1; statusClrIn = 4'b0001;
    step();
    idle();
    chk("upStop", countOut[31:0], 32'd0);
    chk("upClr", {statusOut, irq}, 5'h0);

    // event and clear on the same edge: set wins
    reloadWe = 1'b1; reloadIn = 32'd1;
    configWe = 1'b1; configIn = 4'b1011;
    step();
    idle();
    step(); chk("scCnt1", countOut[31:0], 32'd1);
    statusClrWe = 1'b1; statusClrIn = 4'b0001;
    configWe = 1'b1; configIn = 4'b0000;
    step();
    idle();
    chk("scSetWins", statusOut, 4'b0001);
    chk("scCntWrap", countOut[31:0], 32'd0);
    statusClrWe = 1'b1; statusClrIn = 4'b0001;
    step();
    idle();
    chk("scCleared", {statusOut, irq}, 5'h0);

    // ch1 down with prescale 2
    sel = 2'd1;
    prescaleWe = 1'b1; prescaleIn = 8'd2;
    countWe = 1'b1; countIn = 32'd2;
    reloadWe = 1'b1; reloadIn = 32'd5;
    configWe = 1'b1; configIn = 4'b0001;
    step();
    idle();
    chk("psOut", prescaleOut, 8'd2);
    chk("dn0", countOut[63:32], 32'd2);
    step(2); chk("dnHold", countOut[63:32], 32'd2);
    step(); chk("dn1", countOut[63:32], 32'd1);
    step(2); chk("dn1Hold", countOut[63:32], 32'd1);
    step(); chk("dn2", countOut[63:32], 32'd0);
    chk("dnNoEvt", statusOut, 4'b0000);
    step(3); chk("dnReload", countOut[63:32], 32'd5);
    chk("dnEvtMasked", {statusOut, irq}, {4'b0010, 1'b0});
    prescaleWe = 1'b1; prescaleIn = 8'd0;
    configWe = 1'b1; configIn = 4'b0000;
    statusClrWe = 1'b1; statusClrIn = 4'b0010;
    step();
    idle();
    chk("dnClr", {statusOut, prescaleOut}, 12'h0);

    // ch2 one-shot up, reload 1
    sel = 2'd2;
    reloadWe = 1'b1; reloadIn = 32'd1;
    configWe = 1'b1; configIn = 4'b1111;
    step();
    idle();
    step(2);
    chk("osCnt", countOut[95:64], 32'd0);
    chk("osEnClr", configOut[11:8], 4'b1110);
    chk("osIrq", {statusOut, irq}, {4'b0100, 1'b1});
    step(3);
    chk("osHold", countOut[95:64], 32'd0);
    statusClrWe = 1'b1; statusClrIn = 4'b0100;
    step();
    idle();
    chk("osIrqClr", {statusOut, irq}, 5'h0);

    // ch3 full-width wrap
    sel = 2'd3;
    countWe = 1'b1; countIn = 32'hFFFF_FFFF;
    reloadWe = 1'b1; reloadIn = 32'hFFFF_FFFF;
    configWe = 1'b1; configIn = 4'b0011;
    step();
    idle();
    chk("wrapLoad", countOut[127:96], 32'hFFFF_FFFF);
    step();
    chk("wrapCnt", countOut[127:96], 32'd0);
    chk("wrapEvt", {statusOut, irq}, {4'b1000, 1'b0});
    step();
    chk("wrapNext", countOut[127:96], 32'd1);

    // reset mid-run beats strobes
    reset = 1'b1;
    sel = 2'd0;
    countWe = 1'b1; countIn = 32'h55;
    prescaleWe = 1'b1; prescaleIn = 8'd7;
    step();
    reset = 1'b0;
    idle();
    chk("midRstCount", countOut, 128'h0);
    chk("midRstReload", reloadOut, 128'h0);
    chk("midRstCfg", {configOut, prescaleOut}, 24'h0);
    chk("midRstStatus", {statusOut, irq}, 5'h0);

    // sel 3 is out of range on the 3-channel instance
    sel = 2'd3;
    countWe = 1'b1; countIn = 32'hAB;
    reloadWe = 1'b1; reloadIn = 32'hCD;
    configWe = 1'b1; configIn = 4'b1110;
    step();
    idle();
    chk("selOkCnt", countOut[127:96], 32'hAB);
    chk("selBadCnt", countOut3, 24'h0);
    chk("selBadRld", {reloadOut3, configOut3}, 36'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
